// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states and bus constants for the I2C register-file target
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } i2c_state_e;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic [6:0] ADV7513_ADDR = 7'h39;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: SCL/SDA synchronizer with registered edge, START and STOP pulses
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl_q, scl_n, sda_n;
  assign scl_n = scl_s[SYNC_STAGES-1];
  assign sda_n = sda_s[SYNC_STAGES-1];
  // sync chains reset to the idle-bus level so reset release never fakes a START
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_q <= 1'b1;
      sda <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start <= 1'b0;
      stop <= 1'b0;
    end else begin
      scl_s <= (scl_s << 1) | SYNC_STAGES'(i_scl);
      sda_s <= (sda_s << 1) | SYNC_STAGES'(i_sda);
      scl_q <= scl_n;
      sda <= sda_n;
      scl_rise <= scl_n & ~scl_q;
      scl_fall <= ~scl_n & scl_q;
      start <= scl_n & scl_q & sda & ~sda_n;
      stop <= scl_n & scl_q & ~sda & sda_n;
    end
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing a 256x8 register file at a fixed 7-bit address
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = ADV7513_ADDR,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy
);
  logic scl_rise, scl_fall, start, stop, sda;
  i2c_state_e state;
  logic [2:0] cnt;
  logic [7:0] shift, ptr, byte_in;
  logic [7:0] regs [256];
  logic rw, last;
  assign byte_in = {shift[6:0], sda};
  assign last = cnt == 3'd7;
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk(i_clk), .i_reset(i_reset), .i_scl(i_scl), .i_sda(i_sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda(sda)
  );
  // protocol FSM; ACK states drive SDA on the first SCL fall and release on the second
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      ptr <= '0;
      rw <= 1'b0;
      o_sda_oe <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_busy <= 1'b0;
      for (int i = 0; i < 256; i++) regs[i] <= '0;
    end else begin
      o_wr_valid <= 1'b0;
      if (stop) begin
        state <= IDLE;
        o_busy <= 1'b0;
        o_sda_oe <= 1'b0;
      end else if (start) begin
        state <= ADDR;
        cnt <= '0;
        o_busy <= 1'b1;
        o_sda_oe <= 1'b0;
      end else
        case (state)
          ADDR, PTR, WDATA:
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              shift <= byte_in;
              if (last) begin
                if (state == ADDR) begin
                  if (byte_in[7:1] == TARGET_ADDR) begin
                    state <= ADDR_ACK;
                    rw <= byte_in[0];
                  end else begin
                    state <= IGNORE;
                    o_busy <= 1'b0;
                  end
                end else if (state == PTR) begin
                  ptr <= byte_in;
                  state <= PTR_ACK;
                end else begin
                  regs[ptr] <= byte_in;
                  o_wr_valid <= 1'b1;
                  o_wr_addr <= ptr;
                  o_wr_data <= byte_in;
                  ptr <= ptr + 8'd1;
                  state <= WDATA_ACK;
                end
              end
            end
          ADDR_ACK, PTR_ACK, WDATA_ACK:
            if (scl_fall) begin
              o_sda_oe <= ~o_sda_oe;
              if (o_sda_oe) begin
                if (state == ADDR_ACK && rw) begin
                  state <= RDATA;
                  shift <= regs[ptr];
                  o_sda_oe <= ~regs[ptr][7];
                end else
                  state <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          RDATA: begin
            if (scl_rise) begin
              shift <= shift << 1;
              cnt <= cnt + 3'd1;
              if (last) state <= RDATA_ACK;
            end
            if (scl_fall) o_sda_oe <= ~shift[7];
          end
          RDATA_ACK: begin
            if (scl_fall) o_sda_oe <= 1'b0;
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                ptr <= ptr + 8'd1;
                shift <= regs[ptr + 8'd1];
                state <= RDATA;
              end else
                state <= IGNORE;
            end
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed I2C master transactions against the register-file target
module tb_i2c_target_regfile;
  import i2c_pkg::*;
  localparam time Q = 100ns;
  logic clk = 0, rst = 1, scl = 1, sda_m = 1;
  logic sda_bus, sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  logic [15:0] wq[$];
  logic oe_seen = 0;
  int n_checks = 0, n_fail = 0;
  assign sda_bus = sda_m & ~sda_oe;
  always #5ns clk = ~clk;
  i2c_target_regfile dut (
    .i_clk(clk), .i_reset(rst), .i_scl(scl), .i_sda(sda_bus),
    .o_sda_oe(sda_oe), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_busy(busy)
  );
  always @(negedge clk) begin
    if (wr_valid) wq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic i2c_start();
    sda_m = 1; #Q; scl = 1; #Q; sda_m = 0; #Q; scl = 0; #Q;
  endtask
  task automatic i2c_stop();
    sda_m = 0; #Q; scl = 1; #Q; sda_m = 1; #Q;
    repeat (10) @(negedge clk);
  endtask
  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl = 1; #(2 * Q); scl = 0; #Q;
  endtask
  task automatic read_bit(output logic b);
    sda_m = 1; #Q; scl = 1; #Q; b = sda_bus; #Q; scl = 0; #Q;
  endtask
  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask
  task automatic recv_byte(input logic ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(ack);
  endtask
  task automatic write_txn(input logic [7:0] reg_a, input logic [7:0] d, input string tag);
    logic a0, a1, a2;
    i2c_start();
    send_byte(8'h72, a0);
    send_byte(reg_a, a1);
    send_byte(d, a2);
    i2c_stop();
    check({tag, "_acks"}, {a0, a1, a2}, 3'b000);
  endtask
  initial begin
    logic ack, b;
    logic [7:0] d;
    logic [15:0] cfg [4];
    cfg = '{16'h4110, 16'h9803, 16'h9AE0, 16'hD6C0};
    repeat (5) @(negedge clk);
    check("rst_oe", sda_oe, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    repeat (10) @(negedge clk);
    // single register write
    i2c_start();
    check("t1_busy", busy, 1);
    send_byte(8'h72, ack); check("t1_ack_addr", ack, 0);
    send_byte(8'h98, ack); check("t1_ack_ptr", ack, 0);
    send_byte(8'h03, ack); check("t1_ack_data", ack, 0);
    i2c_stop();
    check("t1_busy_stop", busy, 0);
    check("t1_nwr", wq.size(), 1);
    check("t1_wr0", wq.pop_front(), 16'h9803);
    // read back register 0x98 via repeated START
    i2c_start(); send_byte(8'h72, ack); send_byte(8'h98, ack);
    i2c_start(); send_byte(8'h73, ack); check("t1b_ack_rd", ack, 0);
    recv_byte(I2C_NACK, d); check("t1b_rd", d, 8'h03);
    i2c_stop();
    check("t1b_nwr", wq.size(), 0);
    // burst write with pointer wrap
    i2c_start();
    send_byte(8'h72, ack); send_byte(8'hFE, ack);
    send_byte(8'h11, ack); send_byte(8'h22, ack);
    send_byte(8'h33, ack); check("t2_ack_last", ack, 0);
    i2c_stop();
    check("t2_nwr", wq.size(), 3);
    check("t2_wr0", wq.pop_front(), 16'hFE11);
    check("t2_wr1", wq.pop_front(), 16'hFF22);
    check("t2_wr2", wq.pop_front(), 16'h0033);
    // burst read, ACK then NACK
    i2c_start(); send_byte(8'h72, ack); send_byte(8'hFE, ack);
    i2c_start(); send_byte(8'h73, ack); check("t3_ack_rd", ack, 0);
    recv_byte(I2C_ACK, d); check("t3_rd0", d, 8'h11);
    recv_byte(I2C_NACK, d); check("t3_rd1", d, 8'h22);
    repeat (5) @(negedge clk);
    check("t3_ignore", 32'(dut.state), 32'(IGNORE));
    i2c_stop();
    check("t3_idle", 32'(dut.state), 32'(IDLE));
    // address mismatch
    oe_seen = 0;
    i2c_start();
    send_byte(8'h74, ack); check("t4_nack", ack, 1);
    check("t4_busy", busy, 0);
    send_byte(8'h10, ack); send_byte(8'h55, ack);
    i2c_stop();
    check("t4_oe_never", oe_seen, 0);
    check("t4_nwr", wq.size(), 0);
    // reset mid-read while target is pulling SDA low (reg 0x00 = 0x33, 5th bit 0)
    i2c_start(); send_byte(8'h72, ack); send_byte(8'h00, ack);
    i2c_start(); send_byte(8'h73, ack);
    for (int i = 0; i < 4; i++) read_bit(b);
    sda_m = 1; #Q; scl = 1; #Q;
    check("t5_oe_before", sda_oe, 1);
    rst = 1; #1;
    check("t5_oe_reset", sda_oe, 0);
    check("t5_busy_reset", busy, 0);
    repeat (5) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    i2c_start(); send_byte(8'h73, ack); check("t5_ack_rd", ack, 0);
    recv_byte(I2C_NACK, d); check("t5_rd_cleared", d, 8'h00);
    i2c_stop();
    // configuration-style sequence of independent writes
    wq.delete();
    for (int i = 0; i < 4; i++) write_txn(cfg[i][15:8], cfg[i][7:0], "t6");
    check("t6_nwr", wq.size(), 4);
    for (int i = 0; i < 4; i++) if (wq.size() > 0) check("t6_wr", wq.pop_front(), cfg[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

I2C target (responder) with a 256×8 register file, answering on a configurable 7-bit address. It is the counterpart of the HDMI transmitter's I2C configuration initiator. It sits in the bench and in board-level loopback builds as a stand-in for the ADV7513 register map, so that initiator sequences can be checked register-by-register. It is fully synchronous to one fast system clock, which oversamples SCL/SDA.

## Interface

Parameters:
- `TARGET_ADDR`, default 7'h39: 7-bit device address matched after START.
- `SYNC_STAGES`, default 2: synchronizer depth on SCL/SDA.

Ports:
- `i_clk`  in  1: system clock; must be at least 16× the SCL frequency.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_scl`  in  1: raw SCL pad input.
- `i_sda`  in  1: raw SDA pad input.
- `o_sda_oe`  out  1: 1 pulls SDA low (open drain); 0 releases it.
- `o_wr_valid`  out  1: one-cycle pulse per data byte written to the register file.
- `o_wr_addr`  out  8: register index of that write.
- `o_wr_data`  out  8: byte written.
- `o_busy`  out  1: high from a START until a STOP or an address mismatch.

## Operation

- Sync and edge detection: `i_scl` and `i_sda` each pass through `SYNC_STAGES` flops. Registered previous values produce `scl_rise`, `scl_fall`, `start` and `stop`.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - A STOP from any state goes to IDLE.
  - A START from any state goes to ADDR, with the bit counter cleared (this covers repeated START).
- Shift rules: bits are sampled MSB first on `scl_rise`. The bit counter runs 0..7; the 8th rise completes the byte.
- ADDR: after 8 bits, compare bits [7:1] with `TARGET_ADDR`.
  - Match: go to ADDR_ACK and latch the R/W bit.
  - Mismatch: go to IGNORE, keep `o_sda_oe`=0, wait for START or STOP.
- ACK drive: `o_sda_oe` is asserted on the `scl_fall` that ends the 8th bit. It is released on the next `scl_fall`.
- After ADDR_ACK:
  - W: go to PTR.
  - R: go to RDATA and load the shift register with `regs[ptr]`.
- Pointer path: PTR then PTR_ACK loads `ptr`, then go to WDATA.
- Write path: WDATA then WDATA_ACK writes `regs[ptr]`, pulses `o_wr_valid`, increments `ptr`, and returns to WDATA.
- Read path:
  - In RDATA, `o_sda_oe` = ~shift[7], updated on each `scl_fall`.
  - After the 8th bit, SDA is released for RDATA_ACK.
  - Master ACK (SDA low on `scl_rise`): increment `ptr`, reload from `regs[ptr]`, go to RDATA.
  - Master NACK: go to IGNORE.
- `ptr` is 8 bits and wraps from 0xFF to 0x00. `ptr` persists across transactions.
- Reset values:
  - Every output is 0.
  - State is IDLE; `ptr` = 0x00.
  - All `regs` are 0x00.

## Timing

- Input latency: `SYNC_STAGES`+1 cycles from a pad edge to its event pulse.
- The `o_sda_oe` change is registered: 1 cycle after the `scl_fall` pulse. This is well within SCL low time at ≥16× oversampling.
- `o_wr_valid`, `o_wr_addr` and `o_wr_data` are registered. They assert 1 cycle after the `scl_rise` that samples the 8th data bit, so the write is committed before the ACK bit is driven.
- A data byte is written even if the master aborts with START or STOP during the ACK slot. A byte that is incomplete when START or STOP arrives is discarded.
- Simultaneous events: `start`/`stop` take priority over `scl_rise` or `scl_fall` in the same cycle.
- Asserting `i_reset` mid-transfer releases SDA within the same cycle (async clear of `o_sda_oe`) and discards all progress.

## Structure

- Package `i2c_pkg` holds:
  - the FSM state enum;
  - `I2C_ACK` / `I2C_NACK` constants;
  - the default ADV7513 address constant 7'h39.
- Sub-module `i2c_sync_edge`: synchronizer plus registered edge/START/STOP detector, parameterized by `SYNC_STAGES`.
- The top FSM, shift register and register file remain in `i2c_target_regfile`.

## Test plan

- Write 0x72, 0x98, 0x03 then STOP → ACK on all three bytes; `o_wr_valid` pulses once with addr 0x98, data 0x03; `regs[0x98]`=0x03.
- Burst write 0x72, 0xFE, 0x11, 0x22, 0x33 → writes land at 0xFE, 0xFF, 0x00 (pointer wrap); three pulses.
- Write pointer 0xFE, repeated START, 0x73, read two bytes with ACK then NACK → SDA returns 0x11, 0x22; FSM in IGNORE; STOP → IDLE.
- Address 0x74 → `o_sda_oe` stays 0 for the whole transaction; no `o_wr_valid` pulses; `o_busy` falls at the mismatch.
- Assert `i_reset` during the 5th bit of a data byte → `o_sda_oe`=0 immediately; the next transaction reads 0x00 from register 0x00.
- Initiator loopback (I2C configuration initiator at 20 kHz, `i_clk` 50 MHz) → every programmed (address, data) pair appears on `o_wr_*` in order.
